// File: rtl/seq_adder16_if.sv
// Bus bundle for the nibble-serial adder/subtractor: request side
// (start, op select, operands) and response side (status, result, flags).
interface seq_adder16_if #(
  parameter int N_NIB = 4
);
  localparam int W = 4 * N_NIB;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  // Requester drives operands, the adder returns result and flags
  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/seq_adder16.sv
// Nibble-serial W-bit adder/subtractor built around a single 4-bit
// carry-lookahead cell. One nibble per clock, LSB first; subtraction is
// A + ~B + 1 with the +1 entering as the initial carry.

// 4-bit carry-lookahead cell; o_carry[0] is the carry in, o_carry[4] the carry out.
module CLA4bits (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic [4:0] o_carry
);
  logic [3:0] w_p;
  logic [3:0] w_g;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign o_carry[0] = i_cin;
  assign o_carry[1] = w_g[0] | (w_p[0] & i_cin);
  assign o_carry[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign o_carry[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                    | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_carry[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                    | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                    | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_sum = w_p ^ o_carry[3:0];
endmodule

module seq_adder16 #(
  parameter int N_NIB = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_adder16_if.slave  bus
);
  localparam int W     = 4 * N_NIB;
  localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_last_nib;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_sub;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic [4:0]       w_carry;
  logic [W-1:0]     w_result_next;
  logic             w_unused_carry;

  // A request is taken in IDLE or DONE; requests seen during RUN are dropped
  assign w_accept   = bus.start && (r_state != S_RUN);
  assign w_last_nib = (r_state == S_RUN) && (r_idx == IDX_W'(N_NIB - 1));

  // Current nibble; B is inverted for subtraction
  assign w_a_nib = r_a[4*r_idx +: 4];
  assign w_b_nib = r_sub ? ~r_b[4*r_idx +: 4] : r_b[4*r_idx +: 4];

  CLA4bits u_cla (
    .i_a     (w_a_nib),
    .i_b     (w_b_nib),
    .i_cin   (r_carry),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Low internal carries only matter inside the cell
  assign w_unused_carry = ^w_carry[2:0];

  // Result with the current nibble slot replaced by the fresh sum while running
  for (genvar gi = 0; gi < N_NIB; gi++) begin : g_nib
    assign w_result_next[4*gi +: 4] =
      ((r_state == S_RUN) && (r_idx == IDX_W'(gi))) ? w_sum : r_result[4*gi +: 4];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and status outputs
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last_nib) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = bus.start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, nibble stepping and flag registration on the last nibble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_sub    <= bus.sub;
      r_carry  <= bus.sub;
      r_idx    <= '0;
      r_result <= '0;
    end else if (r_state == S_RUN) begin
      r_result <= w_result_next;
      r_carry  <= w_carry[4];
      if (w_last_nib) begin
        r_cout <= w_carry[4];
        r_ovf  <= w_carry[3] ^ w_carry[4];
        r_zero <= (w_result_next == '0);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = r_zero;
endmodule

// File: tb/tb_seq_adder16.sv
// Directed-vector and random checks for seq_adder16 at the default width.
module tb_seq_adder16;
  localparam int N_NIB = 4;
  localparam int W     = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_adder16_if #(.N_NIB(N_NIB)) bus ();

  seq_adder16 #(.N_NIB(N_NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: full-width add of a and (possibly inverted) b plus the sub carry-in
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       output logic [W-1:0] r, output logic c, output logic o, output logic z);
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb = ms ? ~mb : mb;
    s  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ms};
    r  = s[W-1:0];
    c  = s[W];
    o  = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
    z  = (r == '0);
  endtask

  // Issue one operation from a post-edge point, wait for done, return to IDLE
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        output logic [W-1:0] r, output logic c, output logic o,
                        output logic z, output int lat);
    bus.a = ta; bus.b = tb; bus.sub = ts; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 20);
    r = bus.result; c = bus.cout; o = bus.ovf; z = bus.zero;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t         vecs [8];
    logic [W-1:0] r;
    logic         c, o, z;
    logic [W-1:0] er;
    logic         ec, eo, ez;
    int           lat;
    int           n;
    int           pulses;

    total = 0;
    bad   = 0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1; bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {31'd0, bus.busy}, 32'd0);
    chk("reset_done",   {31'd0, bus.done}, 32'd0);
    chk("reset_result", {16'd0, bus.result}, 32'd0);
    chk("reset_flags",  {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, c, o, z, lat);
      $display("vec %0d: a=%h b=%h sub=%0d -> res=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].sub, r, c, o, z, lat);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_result", i), {16'd0, r}, {16'd0, vecs[i].res});
      chk($sformatf("vec%0d_flags", i), {29'd0, c, o, z},
          {29'd0, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
      chk($sformatf("vec%0d_done_gone", i), {31'd0, bus.done}, 32'd0);
      chk($sformatf("vec%0d_hold", i), {16'd0, bus.result}, {16'd0, vecs[i].res});
    end

    // start held high through RUN while operands change: first operands win
    bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    do begin
      bus.a = 16'(($urandom)); bus.b = 16'(($urandom)); bus.sub = ~bus.sub;
      @(posedge clk); #1;
      n++;
      chk($sformatf("hold_busy_c%0d", n), {31'd0, bus.busy}, (n < 4) ? 32'd1 : 32'd0);
    end while (!bus.done && n < 20);
    bus.start = 1'b0;
    $display("start-held op: res=%h lat=%0d", bus.result, n);
    chk("hold_latency", n, 4);
    chk("hold_result", {16'd0, bus.result}, 32'h3333);
    @(posedge clk); #1;

    // Back-to-back: start in the DONE cycle restarts without an IDLE cycle
    bus.a = 16'h0100; bus.b = 16'h0200; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0; pulses = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.done && n < 20);
    pulses += bus.done;
    chk("b2b_first_latency", n, 4);
    chk("b2b_first_result", {16'd0, bus.result}, 32'h0300);
    bus.a = 16'h0009; bus.b = 16'h0003; bus.sub = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_no_idle", {31'd0, bus.busy}, 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      pulses += bus.done;
    end while (!bus.done && n < 20);
    chk("b2b_second_latency", n, 4);
    chk("b2b_second_result", {16'd0, bus.result}, 32'h0006);
    chk("b2b_second_cout", {31'd0, bus.cout}, 32'd1);
    @(posedge clk); #1;
    pulses += bus.done;
    chk("b2b_pulses", pulses, 2);
    $display("back-to-back: 0100+0200 then 0009-0003 -> res=%h pulses=%0d", bus.result, pulses);

    // Reset in the second RUN cycle aborts asynchronously
    bus.a = 16'h1234; bus.b = 16'h1111; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("abort_partial", {16'd0, bus.result}, 32'h0005);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy",   {31'd0, bus.busy}, 32'd0);
    chk("abort_done",   {31'd0, bus.done}, 32'd0);
    chk("abort_result", {16'd0, bus.result}, 32'd0);
    chk("abort_flags",  {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; pulses += bus.done; end
    chk("abort_no_done", pulses, 0);
    run_op(16'h0001, 16'h0001, 1'b0, r, c, o, z, lat);
    $display("after reset: 0001+0001 -> res=%h lat=%0d", r, lat);
    chk("post_reset_latency", lat, 4);
    chk("post_reset_result", {16'd0, r}, 32'h0002);

    // Random regression
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      model(ra, rb, rs, er, ec, eo, ez);
      run_op(ra, rb, rs, r, c, o, z, lat);
      $display("rnd %0d: a=%h b=%h sub=%0d -> res=%h c=%0d o=%0d z=%0d", i, ra, rb, rs, r, c, o, z);
      chk($sformatf("rnd%0d", i), {11'd0, lat[1:0], c, o, z, r}, {11'd0, 2'd0, ec, eo, ez, er});
      if (lat != 4) chk($sformatf("rnd%0d_latency", i), lat, 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
